// File: rtl/mem_pkg.sv
// Shared definitions for the memory stage: funct3 access codes,
// FSM state type and byte-lane helpers.
package mem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   localparam logic [3:0] LANE_B = 4'b0001;
   localparam logic [3:0] LANE_H = 4'b0011;
   localparam logic [3:0] LANE_W = 4'b1111;

   // Byte-enable for a store of size f3 at byte offset off.
   function automatic logic [3:0] lane_mask(
      input logic [2:0] f3,
      input logic [1:0] off
   );
      logic [3:0] m;
      m = 4'b0000;
      unique case (1'b1)
         (f3 == F3_B): m = LANE_B << off;
         (f3 == F3_H): m = LANE_H << {off[1], 1'b0};
         (f3 == F3_W): m = LANE_W;
         default:      m = 4'b0000;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/mem_stage_ws_dmem_bank.sv
// Data memory bank: byte-enable synchronous write, combinational read.
// Ports: clk, we, be[XLEN/8], addr[log2 DEPTH], wdata -> rdata.
module dmem_bank #(
   parameter int XLEN        = 32,
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [XLEN/8-1:0] be,
   input  logic [AW-1:0]     addr,
   input  logic [XLEN-1:0]   wdata,
   output logic [XLEN-1:0]   rdata
);

   // Power-up image; reset never touches the array.
   logic [XLEN-1:0] mem [DEPTH_WORDS] = '{10: XLEN'(2), default: '0};

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < XLEN/8; i++) begin
            if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   // Read returns pre-write data when a write hits the same word.
   assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage_ws.sv
// Memory stage with configurable wait states and fault detection.
// Ports: *_M controls/data in, stall_M out, registered *_W to writeback.
module mem_stage_ws
   import mem_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            regwrt_M,
   input  logic            memwrite_M,
   input  logic            memread_M,
   input  logic            resultctrl_M,
   input  logic [2:0]      funct3_M,
   input  logic [4:0]      RD_M,
   input  logic [XLEN-1:0] PC_1DEM,
   input  logic [XLEN-1:0] writedata_M,
   input  logic [XLEN-1:0] ALUresult_M,
   output logic            stall_M,
   output logic            regwrt_W,
   output logic            resultctrl_W,
   output logic [4:0]      RD_W,
   output logic [XLEN-1:0] PC_1DEMW,
   output logic [XLEN-1:0] ALUresult_W,
   output logic [XLEN-1:0] Readdata_W,
   output logic            fault_W
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic HAS_WAIT = (WAIT_CYCLES > 0);
   localparam logic [2:0] CNT_INIT =
      3'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

   state_t state, state_nx;
   logic [2:0] cnt, cnt_nx;

   logic access, is_store, is_load;
   logic f3_b, f3_h, f3_w, f3_bu, f3_hu;
   logic illegal, misal, fault, go, we;
   logic [1:0] off;
   logic [AW-1:0] idx;
   logic [3:0] be;
   logic [XLEN-1:0] wdata, rdata, load_val;
   logic [7:0] byte_v;
   logic [15:0] half_v;

   // A request with both strobes set is a store.
   assign access   = memread_M | memwrite_M;
   assign is_store = memwrite_M;
   assign is_load  = memread_M & ~memwrite_M;

   assign f3_b  = (funct3_M == F3_B);
   assign f3_h  = (funct3_M == F3_H);
   assign f3_w  = (funct3_M == F3_W);
   assign f3_bu = (funct3_M == F3_BU);
   assign f3_hu = (funct3_M == F3_HU);

   assign off = ALUresult_M[1:0];
   assign idx = ALUresult_M[AW+1:2];

   assign illegal = is_store ? ~(f3_b | f3_h | f3_w)
                             : ~(f3_b | f3_h | f3_w | f3_bu | f3_hu);
   assign misal   = ((f3_h | f3_hu) & off[0]) | (f3_w & (off != 2'b00));
   assign fault   = access & (illegal | misal);
   assign go      = access & ~fault & HAS_WAIT;

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (rst) cnt <= '0;
      else     cnt <= cnt_nx;
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      unique case (state)
         S_IDLE: begin
            if (go) begin
               state_nx = S_WAIT;
               cnt_nx   = CNT_INIT;
            end
         end
         S_WAIT: begin
            if (cnt == 3'd0) state_nx = S_IDLE;
            else             cnt_nx   = cnt - 3'd1;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Stall starts combinationally in IDLE; the cycle with cnt==0
   // in WAIT is the single commit cycle.
   always_comb begin
      stall_M = 1'b0;
      if (!rst) begin
         unique case (state)
            S_IDLE:  stall_M = go;
            S_WAIT:  stall_M = (cnt != 3'd0);
            default: stall_M = 1'b0;
         endcase
      end
   end

   assign we = is_store & ~fault & ~stall_M & ~rst;
   assign be = lane_mask(funct3_M, off);

   always_comb begin
      wdata = writedata_M;
      unique case (1'b1)
         f3_b:    wdata = {4{writedata_M[7:0]}};
         f3_h:    wdata = {2{writedata_M[15:0]}};
         default: wdata = writedata_M;
      endcase
   end

   dmem_bank #(
      .XLEN        (XLEN),
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_bank (
      .clk   (clk),
      .we    (we),
      .be    (be),
      .addr  (idx),
      .wdata (wdata),
      .rdata (rdata)
   );

   assign byte_v = rdata[{off, 3'b000} +: 8];
   assign half_v = rdata[{off[1], 4'b0000} +: 16];

   always_comb begin
      load_val = '0;
      unique case (1'b1)
         f3_b:    load_val = {{(XLEN-8){byte_v[7]}}, byte_v};
         f3_h:    load_val = {{(XLEN-16){half_v[15]}}, half_v};
         f3_w:    load_val = rdata;
         f3_bu:   load_val = {{(XLEN-8){1'b0}}, byte_v};
         f3_hu:   load_val = {{(XLEN-16){1'b0}}, half_v};
         default: load_val = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || stall_M) begin
         regwrt_W     <= 1'b0;
         resultctrl_W <= 1'b0;
         RD_W         <= '0;
         PC_1DEMW     <= '0;
         ALUresult_W  <= '0;
         Readdata_W   <= '0;
         fault_W      <= 1'b0;
      end else begin
         regwrt_W     <= regwrt_M & ~fault;
         resultctrl_W <= resultctrl_M;
         RD_W         <= RD_M;
         PC_1DEMW     <= PC_1DEM;
         ALUresult_W  <= ALUresult_M;
         Readdata_W   <= (is_load & ~fault) ? load_val : '0;
         fault_W      <= fault;
      end
   end

endmodule

// File: tb/tb_mem_stage_ws.sv
// Directed bench for mem_stage_ws with WAIT_CYCLES = 0, 3 and 4.
// Unit under test is chosen by cur; idle units are held in reset.
module tb_mem_stage_ws;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_v [3];
   logic regwrt_M, memwrite_M, memread_M, resultctrl_M;
   logic [2:0] funct3_M;
   logic [4:0] RD_M;
   logic [31:0] PC_1DEM, writedata_M, ALUresult_M;

   logic st [3];
   logic rw [3];
   logic rc [3];
   logic ft [3];
   logic [4:0] rd [3];
   logic [31:0] pc [3];
   logic [31:0] alu [3];
   logic [31:0] rdat [3];

   int n_tests = 0;
   int n_fail = 0;
   int cur = 0;

   mem_stage_ws #(.WAIT_CYCLES(0)) u_w0 (
      .clk(clk), .rst(rst_v[0]),
      .regwrt_M(regwrt_M), .memwrite_M(memwrite_M),
      .memread_M(memread_M), .resultctrl_M(resultctrl_M),
      .funct3_M(funct3_M), .RD_M(RD_M), .PC_1DEM(PC_1DEM),
      .writedata_M(writedata_M), .ALUresult_M(ALUresult_M),
      .stall_M(st[0]), .regwrt_W(rw[0]), .resultctrl_W(rc[0]),
      .RD_W(rd[0]), .PC_1DEMW(pc[0]), .ALUresult_W(alu[0]),
      .Readdata_W(rdat[0]), .fault_W(ft[0])
   );

   mem_stage_ws #(.WAIT_CYCLES(3)) u_w3 (
      .clk(clk), .rst(rst_v[1]),
      .regwrt_M(regwrt_M), .memwrite_M(memwrite_M),
      .memread_M(memread_M), .resultctrl_M(resultctrl_M),
      .funct3_M(funct3_M), .RD_M(RD_M), .PC_1DEM(PC_1DEM),
      .writedata_M(writedata_M), .ALUresult_M(ALUresult_M),
      .stall_M(st[1]), .regwrt_W(rw[1]), .resultctrl_W(rc[1]),
      .RD_W(rd[1]), .PC_1DEMW(pc[1]), .ALUresult_W(alu[1]),
      .Readdata_W(rdat[1]), .fault_W(ft[1])
   );

   mem_stage_ws #(.WAIT_CYCLES(4)) u_w4 (
      .clk(clk), .rst(rst_v[2]),
      .regwrt_M(regwrt_M), .memwrite_M(memwrite_M),
      .memread_M(memread_M), .resultctrl_M(resultctrl_M),
      .funct3_M(funct3_M), .RD_M(RD_M), .PC_1DEM(PC_1DEM),
      .writedata_M(writedata_M), .ALUresult_M(ALUresult_M),
      .stall_M(st[2]), .regwrt_W(rw[2]), .resultctrl_W(rc[2]),
      .RD_W(rd[2]), .PC_1DEMW(pc[2]), .ALUresult_W(alu[2]),
      .Readdata_W(rdat[2]), .fault_W(ft[2])
   );

   task automatic chk(
      input string tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic set_in(
      input logic rwi, input logic mr, input logic mw,
      input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd
   );
      regwrt_M     = rwi;
      memread_M    = mr;
      memwrite_M   = mw;
      resultctrl_M = mr;
      funct3_M     = f3;
      ALUresult_M  = a;
      writedata_M  = wd;
      RD_M         = 5'd9;
      PC_1DEM      = a + 32'd4;
   endtask

   // Drive one op, hold it through nst stall cycles, then check W.
   task automatic op(
      input string tag,
      input logic rwi, input logic mr, input logic mw,
      input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
      input int nst,
      input logic [31:0] e_rd, input logic e_rw, input logic e_ft
   );
      set_in(rwi, mr, mw, f3, a, wd);
      for (int k = 0; k <= nst; k++) begin
         #1;
         chk({tag, ":stall"}, 32'(st[cur]), 32'(k < nst));
         @(posedge clk);
         #1;
         if (k < nst) begin
            chk({tag, ":bub_rw"}, 32'(rw[cur]), 32'd0);
            chk({tag, ":bub_alu"}, alu[cur], 32'd0);
         end
      end
      chk({tag, ":rdata"}, rdat[cur], e_rd);
      chk({tag, ":rw"}, 32'(rw[cur]), 32'(e_rw));
      chk({tag, ":fault"}, 32'(ft[cur]), 32'(e_ft));
      chk({tag, ":alu"}, alu[cur], a);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) rst_v[i] = 1'b1;
      set_in(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("rst_rw", 32'(rw[i]), 32'd0);
         chk("rst_fault", 32'(ft[i]), 32'd0);
         chk("rst_rdata", rdat[i], 32'd0);
         chk("rst_stall", 32'(st[i]), 32'd0);
      end

      // No wait states
      cur = 0;
      rst_v[0] = 1'b0;
      op("w0_lw28", 1, 1, 0, 3'b010, 32'h28, 0, 0, 32'h2, 1, 0);
      chk("w0_lw28:rd", 32'(rd[0]), 32'd9);
      chk("w0_lw28:rc", 32'(rc[0]), 32'd1);
      op("w0_sb41", 0, 0, 1, 3'b000, 32'h41, 32'h80, 0, 0, 0, 0);
      op("w0_lbu41", 1, 1, 0, 3'b100, 32'h41, 0, 0, 32'h80, 1, 0);
      op("w0_lb41", 1, 1, 0, 3'b000, 32'h41, 0, 0, 32'hFFFFFF80, 1, 0);
      op("w0_lw40", 1, 1, 0, 3'b010, 32'h40, 0, 0, 32'h00008000, 1, 0);
      op("w0_lh40", 1, 1, 0, 3'b001, 32'h40, 0, 0, 32'hFFFF8000, 1, 0);
      op("w0_lhu40", 1, 1, 0, 3'b101, 32'h40, 0, 0, 32'h00008000, 1, 0);
      op("w0_lh13", 1, 1, 0, 3'b001, 32'h13, 0, 0, 0, 0, 1);
      op("w0_sw12", 0, 0, 1, 3'b010, 32'h12, 32'hFFFFFFFF, 0, 0, 0, 1);
      op("w0_lw10", 1, 1, 0, 3'b010, 32'h10, 0, 0, 0, 1, 0);
      op("w0_ld011", 1, 1, 0, 3'b011, 32'h28, 0, 0, 0, 0, 1);
      op("w0_st100", 0, 0, 1, 3'b100, 32'h28, 32'h77, 0, 0, 0, 1);
      op("w0_lw28b", 1, 1, 0, 3'b010, 32'h28, 0, 0, 32'h2, 1, 0);
      op("w0_rmw", 0, 1, 1, 3'b001, 32'h2A, 32'hBEEF, 0, 0, 0, 0);
      op("w0_lw28c", 1, 1, 0, 3'b010, 32'h28, 0, 0, 32'hBEEF0002, 1, 0);
      op("w0_sw1000", 0, 0, 1, 3'b010, 32'h1000, 32'h11, 0, 0, 0, 0);
      op("w0_lw0", 1, 1, 0, 3'b010, 32'h0, 0, 0, 32'h11, 1, 0);
      op("w0_alu", 1, 0, 0, 3'b000, 32'h1234, 0, 0, 0, 1, 0);

      // Three wait states
      rst_v[0] = 1'b1;
      cur = 1;
      rst_v[1] = 1'b0;
      op("w3_sw10", 0, 0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 3, 0, 0, 0);
      op("w3_lw10", 1, 1, 0, 3'b010, 32'h10, 0, 3, 32'hDEADBEEF, 1, 0);
      op("w3_lh13", 1, 1, 0, 3'b001, 32'h13, 0, 0, 0, 0, 1);
      op("w3_sb11", 0, 0, 1, 3'b000, 32'h11, 32'h5A, 3, 0, 0, 0);
      op("w3_lw10b", 1, 1, 0, 3'b010, 32'h10, 0, 3, 32'hDEAD5AEF, 1, 0);
      op("w3_alu", 1, 0, 0, 3'b000, 32'h44, 0, 0, 0, 1, 0);

      // Four wait states, reset lands on the 2nd stall cycle
      rst_v[1] = 1'b1;
      cur = 2;
      rst_v[2] = 1'b0;
      set_in(1'b0, 1'b0, 1'b1, 3'b010, 32'h20, 32'h55AA55AA);
      #1;
      chk("w4_st1", 32'(st[2]), 32'd1);
      @(posedge clk);
      #1;
      chk("w4_st2", 32'(st[2]), 32'd1);
      rst_v[2] = 1'b1;
      #1;
      chk("w4_st_rst", 32'(st[2]), 32'd0);
      @(posedge clk);
      #1;
      chk("w4_rst_rw", 32'(rw[2]), 32'd0);
      chk("w4_rst_rc", 32'(rc[2]), 32'd0);
      chk("w4_rst_rd", 32'(rd[2]), 32'd0);
      chk("w4_rst_pc", pc[2], 32'd0);
      chk("w4_rst_alu", alu[2], 32'd0);
      chk("w4_rst_rdata", rdat[2], 32'd0);
      chk("w4_rst_fault", 32'(ft[2]), 32'd0);
      rst_v[2] = 1'b0;
      op("w4_lw20", 1, 1, 0, 3'b010, 32'h20, 0, 4, 32'h0, 1, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
